divmmc_spi: RTL and testbench

SPI host controller for the DivMMC mapper in the ZX core. Converts Z80 accesses to the DivMMC data port (0xEB) and chip-select port (0xE7) into SPI mode-0 byte transfers. Drives the virtual SD card responder (`sdvCs`/`sdvCk`/`sdvMosi`/`sdvMiso`), or the physical card in SPI mode. It is the initiator end of the SD-over-SPI link.

---
 rtl/divmmc_spi_if.sv | 8 +
 rtl/divmmc_spi.sv | 70 +++++++
 tb/tb_divmmc_spi.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/divmmc_spi_if.sv
// divmmc_spi_if: CPU port strobes plus SPI pins of the DivMMC SPI host
interface divmmc_spi_if #(parameter int CSW = 2);
  logic ce, wr, rd, csWr, busy, spiCk, spiMosi, spiMiso;
  logic [7:0] d, q;
  logic [CSW-1:0] spiCs;
  modport master (output ce, wr, rd, csWr, d, spiMiso, input q, busy, spiCs, spiCk, spiMosi);
  modport slave (input ce, wr, rd, csWr, d, spiMiso, output q, busy, spiCs, spiCk, spiMosi);
endinterface

// File: rtl/divmmc_spi.sv
// divmmc_spi: SPI mode-0 byte host for the DivMMC data and chip-select ports
module divmmc_spi #(parameter int CSW = 2) (
  input logic clock,
  input logic reset,
  divmmc_spi_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0, XFER = 1'b1;
  logic [0:0] state_q, state_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d, q_q, q_d, byte_s;
  logic [3:0] cnt_q, cnt_d;
  logic [CSW-1:0] cs_q, cs_d;
  logic ck_q, ck_d, mosi_q, mosi_d, start, step;
  assign start = state_q == IDLE && (bus.wr || bus.rd);
  assign step = state_q == XFER && bus.ce;
  assign byte_s = bus.wr ? bus.d : 8'hFF;
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    rx_d = rx_q;
    q_d = q_q;
    cnt_d = cnt_q;
    ck_d = ck_q;
    mosi_d = mosi_q;
    cs_d = bus.csWr ? bus.d[CSW-1:0] : cs_q;
    if (start) begin
      tx_d = byte_s;
      mosi_d = byte_s[7];
      cnt_d = '0;
      state_d = XFER;
    end else if (step) begin
      cnt_d = cnt_q + 4'd1;
      ck_d = !cnt_q[0];
      if (!cnt_q[0]) rx_d = {rx_q[6:0], bus.spiMiso};
      else begin
        tx_d = {tx_q[6:0], 1'b1};
        mosi_d = tx_q[6];
      end
      if (cnt_q == 4'hF) begin
        q_d = rx_q;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q <= 8'hFF;
      rx_q <= 8'h00;
      q_q <= 8'hFF;
      cnt_q <= '0;
      cs_q <= '1;
      ck_q <= 1'b0;
      mosi_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      cs_q <= cs_d;
      ck_q <= ck_d;
      mosi_q <= mosi_d;
    end
  end
  assign bus.q = q_q;
  assign bus.busy = state_q == XFER;
  assign bus.spiCs = cs_q;
  assign bus.spiCk = ck_q;
  assign bus.spiMosi = mosi_q;
endmodule

// File: tb/tb_divmmc_spi.sv
// tb_divmmc_spi: directed transfers against a byte responder, checked by a completion scoreboard
module tb_divmmc_spi;
  typedef struct {logic [7:0] q, mosi; int lo, hi;} exp_t;
  logic clock = 0, reset = 1;
  divmmc_spi_if #(.CSW(2)) bus();
  divmmc_spi #(.CSW(2)) dut(.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  exp_t exp_q[$];
  int checks = 0, errors = 0, ce_div = 1, ce_cnt = 0, ncyc = 0, nfall = 0;
  logic [7:0] resp_byte = 8'hFF, mosi_sh = 8'h00;
  logic busy_p = 0, ck_p = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    ce_cnt = (ce_cnt + 1) % ce_div;
    bus.ce = ce_cnt == 0;
  end

  // responder and scoreboard monitor, all sampled on the falling clock edge
  initial begin
    bus.spiMiso = 1'b1;
    forever begin
      @(negedge clock);
      if (bus.busy && !busy_p) begin
        ncyc = 0;
        nfall = 0;
      end
      if (bus.busy) ncyc++;
      if (ck_p && !bus.spiCk) nfall++;
      if (!ck_p && bus.spiCk) mosi_sh = {mosi_sh[6:0], bus.spiMosi};
      bus.spiMiso = nfall < 8 ? resp_byte[3'(7 - nfall)] : 1'b1;
      if (busy_p && !bus.busy && !reset) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_q", bus.q, e.q);
          check("done_mosi", mosi_sh, e.mosi);
          checks++;
          if (ncyc < e.lo || ncyc > e.hi) begin
            errors++;
            $display("FAIL busy_len: got %0d expected %0d..%0d", ncyc, e.lo, e.hi);
          end
        end
      end
      busy_p = bus.busy;
      ck_p = bus.spiCk;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_xfer(input logic w, input logic r, input logic [7:0] data, input logic [7:0] resp,
                            input logic [7:0] eq, input logic [7:0] em, input int lo, input int hi);
    exp_t e;
    e = '{eq, em, lo, hi};
    resp_byte = resp;
    bus.wr = w;
    bus.rd = r;
    bus.d = data;
    exp_q.push_back(e);
    tick();
    bus.wr = 0;
    bus.rd = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_timeout", bus.busy, 0);
  endtask

  task automatic wait_ck(input logic v, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.spiCk !== v && n < 400);
    if (bus.spiCk !== v) check("spick_timeout", bus.spiCk, v);
  endtask

  initial begin
    int n;
    bus.wr = 0; bus.rd = 0; bus.csWr = 0; bus.d = 0; bus.ce = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_cs", bus.spiCs, 2'b11);
    check("rst_ck", bus.spiCk, 0);
    check("rst_mosi", bus.spiMosi, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_q", bus.q, 8'hFF);
    tick();
    reset = 0;
    tick();
    start_xfer(1, 0, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 16, 16);
    check("a5_busy", bus.busy, 1);
    check("a5_mosi7", bus.spiMosi, 1);
    wait_idle();
    check("a5_mosi_after", bus.spiMosi, 1);
    check("a5_q", bus.q, 8'h3C);
    start_xfer(0, 1, 8'h77, 8'h01, 8'h01, 8'hFF, 16, 16);
    check("rd_q_prev", bus.q, 8'h3C);
    wait_idle();
    start_xfer(1, 1, 8'h12, 8'h5A, 8'h5A, 8'h12, 16, 16);
    check("wr_wins_mosi7", bus.spiMosi, 0);
    wait_idle();
    start_xfer(1, 0, 8'h81, 8'hE7, 8'hE7, 8'h81, 16, 16);
    repeat (7) tick();
    bus.wr = 1;
    bus.d = 8'h55;
    tick();
    bus.wr = 0;
    wait_idle();
    ce_div = 4;
    repeat (4) tick();
    start_xfer(1, 0, 8'hFF, 8'h00, 8'h00, 8'hFF, 61, 67);
    wait_ck(1, n);
    wait_ck(0, n);
    check("ck_high_w", n, 4);
    wait_ck(1, n);
    check("ck_low_w", n, 4);
    tick();
    bus.csWr = 1;
    bus.d = 8'hFE;
    tick();
    bus.csWr = 0;
    check("cs_mid", bus.spiCs, 2'b10);
    check("cs_busy", bus.busy, 1);
    wait_idle();
    ce_div = 1;
    repeat (3) tick();
    resp_byte = 8'h99;
    bus.wr = 1;
    bus.d = 8'hA5;
    tick();
    bus.wr = 0;
    repeat (9) tick();
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    check("abort_busy", bus.busy, 0);
    check("abort_ck", bus.spiCk, 0);
    check("abort_mosi", bus.spiMosi, 1);
    check("abort_q", bus.q, 8'hFF);
    check("abort_cs", bus.spiCs, 2'b11);
    tick();
    reset = 0;
    tick();
    start_xfer(1, 0, 8'h40, 8'hC3, 8'hC3, 8'h40, 16, 16);
    wait_idle();
    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
